// File: rtl/demux12_32_steer.sv
// Buffered 1-to-2 steering demux: in-order FIFO whose head is routed to channel 0 or 1.
// Optional per-channel transfer counters are enabled with DEMUX12_STATS_EN.
module demux12_32_steer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [WIDTH-1:0]                 in_data,
   input  logic                             in_select,
   output logic                             out0_valid,
   input  logic                             out0_ready,
   output logic [WIDTH-1:0]                 out0_data,
   output logic                             out1_valid,
   input  logic                             out1_ready,
   output logic [WIDTH-1:0]                 out1_data,
   output logic [$clog2(DEPTH+1)-1:0]       level
`ifdef DEMUX12_STATS_EN
   ,
   output logic [15:0]                      xfer0_cnt,
   output logic [15:0]                      xfer1_cnt
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_data [DEPTH];
   logic             mem_sel  [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] head_data;

   logic             push_c, pop_c;
   logic [PTR_W-1:0] rd_ptr_nxt_c, wr_ptr_nxt_c;
   logic [CNT_W-1:0] count_nxt_c, remain_c;
   logic [WIDTH-1:0] head_data_nxt_c;
   logic             head_sel_nxt_c;
   logic             out0_valid_nxt_c, out1_valid_nxt_c, in_ready_nxt_c;

   // Next-state: pointers, occupancy and the head word presented after this edge.
   always_comb begin
      push_c          = in_valid & in_ready;
      pop_c           = (out0_valid & out0_ready) | (out1_valid & out1_ready);
      rd_ptr_nxt_c    = rd_ptr + PTR_W'(pop_c);
      wr_ptr_nxt_c    = wr_ptr + PTR_W'(push_c);
      count_nxt_c     = count;
      head_data_nxt_c = head_data;
      head_sel_nxt_c  = 1'b0;

      case ({push_c, pop_c})
         2'b10:   count_nxt_c = count + CNT_W'(1);
         2'b01:   count_nxt_c = count - CNT_W'(1);
         default: count_nxt_c = count;
      endcase

      // Entries already stored that survive this edge; if none, a new push becomes the head.
      remain_c = count - CNT_W'(pop_c);
      if (remain_c != CNT_W'(0)) begin
         head_data_nxt_c = mem_data[rd_ptr_nxt_c];
         head_sel_nxt_c  = mem_sel[rd_ptr_nxt_c];
      end else if (push_c) begin
         head_data_nxt_c = in_data;
         head_sel_nxt_c  = in_select;
      end

      out0_valid_nxt_c = (count_nxt_c != CNT_W'(0)) & ~head_sel_nxt_c;
      out1_valid_nxt_c = (count_nxt_c != CNT_W'(0)) &  head_sel_nxt_c;
      in_ready_nxt_c   = (count_nxt_c != CNT_W'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_data[i] <= '0;
            mem_sel[i]  <= 1'b0;
         end
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         head_data  <= '0;
         out0_valid <= 1'b0;
         out1_valid <= 1'b0;
         in_ready   <= 1'b1;
      end else begin
         if (push_c) begin
            mem_data[wr_ptr] <= in_data;
            mem_sel[wr_ptr]  <= in_select;
         end
         rd_ptr     <= rd_ptr_nxt_c;
         wr_ptr     <= wr_ptr_nxt_c;
         count      <= count_nxt_c;
         head_data  <= head_data_nxt_c;
         out0_valid <= out0_valid_nxt_c;
         out1_valid <= out1_valid_nxt_c;
         in_ready   <= in_ready_nxt_c;
      end
   end

   assign out0_data = head_data;
   assign out1_data = head_data;
   assign level     = count;

`ifdef DEMUX12_STATS_EN
   // Saturating count of completed pops per channel.
   always_ff @(posedge clk) begin
      if (reset) begin
         xfer0_cnt <= '0;
         xfer1_cnt <= '0;
      end else begin
         if (out0_valid && out0_ready && (xfer0_cnt != 16'hFFFF))
            xfer0_cnt <= xfer0_cnt + 16'd1;
         if (out1_valid && out1_ready && (xfer1_cnt != 16'hFFFF))
            xfer1_cnt <= xfer1_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_demux12_32_steer.sv
// Self-checking bench for demux12_32_steer: queue-based reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_demux12_32_steer;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid, in_select, out0_ready, out1_ready;
   logic [WIDTH-1:0]  in_data;
   logic              in_ready, out0_valid, out1_valid;
   logic [WIDTH-1:0]  out0_data, out1_data;
   logic [1:0]        level;
`ifdef DEMUX12_STATS_EN
   logic [15:0]       xfer0_cnt, xfer1_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   demux12_32_steer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_select(in_select),
      .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
      .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
      .level(level)
`ifdef DEMUX12_STATS_EN
      , .xfer0_cnt(xfer0_cnt), .xfer1_cnt(xfer1_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: a plain queue of {select, data} words.
   typedef struct packed {
      logic             sel;
      logic [WIDTH-1:0] data;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_last = '0;
   int          m_x0 = 0, m_x1 = 0;

   always @(posedge clk) begin : model
      bit m_pop, m_push;
      if (reset) begin
         q.delete();
         m_last = '0;
         m_x0   = 0;
         m_x1   = 0;
      end else begin
         m_pop  = (q.size() > 0) && (q[0].sel ? out1_ready : out0_ready);
         m_push = in_valid && (q.size() < int'(DEPTH));
         if (m_pop) begin
            if (q[0].sel) m_x1 = (m_x1 < 65535) ? m_x1 + 1 : m_x1;
            else          m_x0 = (m_x0 < 65535) ? m_x0 + 1 : m_x0;
            void'(q.pop_front());
         end
         if (m_push) q.push_back({in_select, in_data});
         if (q.size() > 0) m_last = q[0].data;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic e_v0, e_v1;
      e_v0 = (q.size() > 0) && !q[0].sel;
      e_v1 = (q.size() > 0) &&  q[0].sel;
      chk("m_out0_valid", 32'(out0_valid), 32'(e_v0));
      chk("m_out1_valid", 32'(out1_valid), 32'(e_v1));
      chk("m_out0_data",  out0_data, m_last);
      chk("m_out1_data",  out1_data, m_last);
      chk("m_level",      32'(level), 32'(q.size()));
      chk("m_in_ready",   32'(in_ready), 32'(q.size() < int'(DEPTH)));
`ifdef DEMUX12_STATS_EN
      chk("m_xfer0_cnt",  32'(xfer0_cnt), 32'(m_x0));
      chk("m_xfer1_cnt",  32'(xfer1_cnt), 32'(m_x1));
`endif
   endtask

   // Advance one edge, then sample 1ns later and compare against the model.
   task automatic tick();
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic s);
      in_valid  = v;
      in_data   = d;
      in_select = s;
   endtask

   initial begin
      reset = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
      drive(1'b1, 32'hDEADBEEF, 1'b0);

      // Reset while the source is offering a word.
      reset = 1'b1;
      tick();
      chk("rst_out0_valid", 32'(out0_valid), 32'd0);
      chk("rst_out1_valid", 32'(out1_valid), 32'd0);
      chk("rst_level",      32'(level), 32'd0);
      chk("rst_in_ready",   32'(in_ready), 32'd1);
      chk("rst_out0_data",  out0_data, 32'd0);
      chk("rst_out1_data",  out1_data, 32'd0);
      reset = 1'b0;

      // Two words to alternate channels with both sinks ready.
      drive(1'b1, 32'h12345678, 1'b0);
      tick();
      chk("a_out0_valid", 32'(out0_valid), 32'd1);
      chk("a_out0_data",  out0_data, 32'h12345678);
      drive(1'b1, 32'h87654321, 1'b1);
      tick();
      chk("b_out1_valid", 32'(out1_valid), 32'd1);
      chk("b_out0_valid", 32'(out0_valid), 32'd0);
      chk("b_out1_data",  out1_data, 32'h87654321);
      drive(1'b0, 32'h0, 1'b0);
      tick();
      chk("ab_level",     32'(level), 32'd0);
      chk("ab_hold_data", out1_data, 32'h87654321);

      // Fill with channel 0 stalled, then free one entry while a push is offered.
      out0_ready = 1'b0;
      drive(1'b1, 32'hC0C0C0C0, 1'b0); tick();
      drive(1'b1, 32'hD0D0D0D0, 1'b0); tick();
      chk("full_level",    32'(level), 32'd2);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      drive(1'b1, 32'hE0E0E0E0, 1'b0); tick();
      chk("held_level",    32'(level), 32'd2);
      out0_ready = 1'b1;
      tick();
      chk("free_level",    32'(level), 32'd1);
      chk("free_data",     out0_data, 32'hD0D0D0D0);
      tick();
      chk("push_pop_level", 32'(level), 32'd1);
      chk("push_pop_data",  out0_data, 32'hE0E0E0E0);
      drive(1'b0, 32'h0, 1'b0); tick();

      // Head-of-line: channel 0 stalled head blocks a ready channel 1 word.
      out0_ready = 1'b0; out1_ready = 1'b1;
      drive(1'b1, 32'hF0000001, 1'b0); tick();
      drive(1'b1, 32'hF0000002, 1'b1); tick();
      drive(1'b0, 32'h0, 1'b0); tick();
      chk("hol_out1_valid", 32'(out1_valid), 32'd0);
      chk("hol_out0_valid", 32'(out0_valid), 32'd1);
      out0_ready = 1'b1;
      tick();
      chk("hol_rel_valid",  32'(out1_valid), 32'd1);
      chk("hol_rel_data",   out1_data, 32'hF0000002);
      tick();

      // Reset with two words buffered.
      out0_ready = 1'b0; out1_ready = 1'b0;
      drive(1'b1, 32'h11111111, 1'b0); tick();
      drive(1'b1, 32'h22222222, 1'b1); tick();
      chk("pre_rst_level", 32'(level), 32'd2);
      drive(1'b0, 32'h0, 1'b0);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("mid_rst_level", 32'(level), 32'd0);
      chk("mid_rst_v0",    32'(out0_valid), 32'd0);
      chk("mid_rst_v1",    32'(out1_valid), 32'd0);
      chk("mid_rst_data",  out0_data, 32'd0);

      // Three transfers to channel 0 and one to channel 1.
      out0_ready = 1'b1; out1_ready = 1'b1;
      drive(1'b1, 32'hA0, 1'b0); tick();
      drive(1'b1, 32'hA1, 1'b0); tick();
      drive(1'b1, 32'hB0, 1'b1); tick();
      drive(1'b1, 32'hA2, 1'b0); tick();
      drive(1'b0, 32'h0, 1'b0); tick(); tick();
      chk("stat_level", 32'(level), 32'd0);
`ifdef DEMUX12_STATS_EN
      chk("stat_xfer0", 32'(xfer0_cnt), 32'd3);
      chk("stat_xfer1", 32'(xfer1_cnt), 32'd1);
`endif

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 4000; i++) begin
         reset      = ($urandom_range(0, 199) == 0);
         out0_ready = ($urandom_range(0, 3) != 0);
         out1_ready = ($urandom_range(0, 2) != 0);
         drive(($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/demux12_32_steer.md
Name: demux12_32_steer

Overview:
- Buffered 1-to-2 demultiplexer: the steering counterpart of the 2:1 32-bit mux.
- Accepts a stream of 32-bit words, each tagged with a destination select bit.
- Routes each word to output channel 0 or channel 1 through valid/ready handshakes.
- Holds words in an in-order FIFO, so a stalled destination back-pressures the source without dropping or reordering data.
- Used in the processor datapath to steer results, e.g. ALU/load results to the writeback port or forwarding port.

Parameters:
- WIDTH, 32: data word width in bits.
- DEPTH, 2: FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  source has a word.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  word to steer.
- in_select  input  1  destination: 0 -> channel 0, 1 -> channel 1.
- out0_valid  output  1  head word is destined for channel 0.
- out0_ready  input  1  channel 0 sink accepts.
- out0_data  output  WIDTH  head word data.
- out1_valid  output  1  head word is destined for channel 1.
- out1_ready  input  1  channel 1 sink accepts.
- out1_data  output  WIDTH  head word data.
- level  output  clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (clk edge with reset=1):
  - Read pointer, write pointer and count cleared to 0.
  - All storage entries cleared to 0.
  - Outputs after reset: out0_valid=0, out1_valid=0, out0_data=out1_data=0, level=0, in_ready=1.
  - Reset mid-operation discards all buffered words; no partial transfer completes on the reset edge.
- Storage: DEPTH entries of {select, data}; pointers wrap modulo DEPTH.
- Push: in_valid && in_ready at the edge writes {in_select, in_data} at the write pointer, then increments it.
- in_ready = (count != DEPTH). There is no pass-through when full: a word arriving on the edge that frees an entry is not accepted.
- Head presentation:
  - out0_data and out1_data both equal the head entry's data whenever count > 0; they hold the last head value when empty.
  - out0_valid = (count > 0) && (head select == 0).
  - out1_valid = (count > 0) && (head select == 1).
  - At most one valid is ever high.
- Pop: (out0_valid && out0_ready) || (out1_valid && out1_ready) at the edge increments the read pointer.
  - The ready of the non-selected channel is ignored.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop on the same edge (only possible when not full): unchanged.
  - level = count.
- Latency: a word accepted at edge N is visible on the outputs in the cycle after edge N (1 cycle minimum). Back-to-back words with a constantly ready sink sustain 1 word/cycle.
- Ordering: strictly in-order across both channels. A stalled head for channel 0 blocks a following word for channel 1 (head-of-line blocking is intended).
- Data is not modified; widths are pass-through.
- Outputs are driven from registers and the head mux. No combinational path from out*_ready to in_ready.

Optional Feature:
- Macro: DEMUX12_STATS_EN.
- With the macro defined:
  - Adds outputs xfer0_cnt [15:0] and xfer1_cnt [15:0].
  - Each counts completed pops to its channel, increments on the pop edge, and saturates at 16'hFFFF.
  - Both clear to 0 on reset.
- Without the macro: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset with in_valid=1 held -> after the reset edge, both valids=0, level=0, in_ready=1, data outputs=0; no word captured.
- Push 32'h12345678 sel=0, then 32'h87654321 sel=1, both outputs ready:
  - Cycle 1: out0_valid=1 with 32'h12345678.
  - Cycle 2: out1_valid=1 with 32'h87654321.
  - level returns to 0.
- out0_ready=0, push two sel=0 words (DEPTH=2) -> level=2, in_ready=0. A third word is held off until out0_ready=1 frees an entry.
- Head sel=0 stalled (out0_ready=0), second word sel=1, out1_ready=1 -> out1_valid stays 0 until the head pops (in-order check).
- Full FIFO, set out0_ready=1 and in_valid=1 on the same cycle -> pop occurs, push refused that edge, level=1.
- Reset asserted with level=2 -> buffered words lost, outputs idle.
- With DEMUX12_STATS_EN: 3 words to ch0 and 1 to ch1 -> xfer0_cnt=3, xfer1_cnt=1.
